// File: rtl/m_uart_sequencer_pkg.sv
// Shared definitions for the icebreaker serial slave: register offsets, STATUS
// and CTRL bit positions, FSM state encoding and a STATUS packing helper.
// Used by the RTL and by the bench.
package m_uart_sequencer_pkg;

  // Register select (ADR_I)
  localparam logic REG_DATA = 1'b0;
  localparam logic REG_CTRL = 1'b1;

  // STATUS bit positions
  localparam int ST_TXBUSY  = 0;
  localparam int ST_TXFULL  = 1;
  localparam int ST_RXVALID = 2;
  localparam int ST_OVERRUN = 3;
  localparam int ST_TXDROP  = 4;
  localparam int ST_RXS     = 8;

  // CTRL bit positions
  localparam int CTRL_BBMODE = 0;
  localparam int CTRL_BBVAL  = 1;
  localparam int CTRL_CLRERR = 4;

  // Common state encoding for the TX and RX frame FSMs
  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

  function automatic logic [31:0] pack_status(input logic rxs, input logic txdrop,
                                              input logic overrun, input logic rxvalid,
                                              input logic txfull, input logic txbusy);
    logic [31:0] s;
    s              = '0;
    s[ST_RXS]      = rxs;
    s[ST_TXDROP]   = txdrop;
    s[ST_OVERRUN]  = overrun;
    s[ST_RXVALID]  = rxvalid;
    s[ST_TXFULL]   = txfull;
    s[ST_TXBUSY]   = txbusy;
    return s;
  endfunction

endpackage

// File: rtl/m_uart_sequencer_if.sv
// Wishbone IO slot bundle for the serial slave.
// Handshake: STB_I is the request (already qualified by the IO address decode);
// the slave answers with ACK_O = STB_I in the same cycle, so every cycle with
// STB_I high is one complete transfer. WE_I selects write, ADR_I the register.
// DAT_O carries read data and is all zero whenever STB_I is low.
interface m_uart_sequencer_if;
  logic        STB_I;
  logic        WE_I;
  logic        ADR_I;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic        ACK_O;

  modport master (output STB_I, output WE_I, output ADR_I, output DAT_I,
                  input  DAT_O, input  ACK_O);
  modport slave  (input  STB_I, input  WE_I, input  ADR_I, input  DAT_I,
                  output DAT_O, output ACK_O);
endinterface

// File: rtl/m_uart_rx.sv
// 8N1 receiver for the serial slave.
// Ports:
//   CLK_I, RST_I  clock / synchronous active-high reset
//   rx_pin        asynchronous serial input
//   rd_clr        DATA register read this cycle (clears rxvalid)
//   err_clr       CTRL clear-error write this cycle (clears overrun)
//   rxs           synchronized serial input
//   rxbuf         last good byte received
//   rxvalid       rxbuf holds an unread byte
//   overrun       a byte completed while rxvalid was still set
//   state         RX FSM state (debug)
module m_uart_rx
  import m_uart_sequencer_pkg::*;
#(
  parameter int BAUDDIV = 104,
  parameter int DIVW    = 16
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        rx_pin,
  input  logic        rd_clr,
  input  logic        err_clr,
  output logic        rxs,
  output logic [7:0]  rxbuf,
  output logic        rxvalid,
  output logic        overrun,
  output uart_state_e state
);

  localparam logic [DIVW-1:0] FULL_RELOAD = DIVW'(BAUDDIV - 1);
  localparam logic [DIVW-1:0] HALF_RELOAD = DIVW'(BAUDDIV / 2 - 1);

  logic            sync1_q, sync2_q, rxs_prev_q;
  uart_state_e     state_q, state_d;
  logic [DIVW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rxbuf_q, rxbuf_d;
  logic            rxvalid_q, rxvalid_d;
  logic            overrun_q, overrun_d;
  logic            done;

  assign rxs     = sync2_q;
  assign rxbuf   = rxbuf_q;
  assign rxvalid = rxvalid_q;
  assign overrun = overrun_q;
  assign state   = state_q;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rxs_prev_q <= 1'b1;
      state_q    <= UART_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      rxbuf_q    <= '0;
      rxvalid_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sync1_q    <= rx_pin;
      sync2_q    <= sync1_q;
      rxs_prev_q <= sync2_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      rxbuf_q    <= rxbuf_d;
      rxvalid_q  <= rxvalid_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    rxbuf_d   = rxbuf_q;
    rxvalid_d = rxvalid_q;
    overrun_d = overrun_q;
    done      = 1'b0;

    case (state_q)
      UART_IDLE: begin
        // Only a real falling edge starts a frame; a line stuck low after a
        // framing error must first return high.
        if (rxs_prev_q && !sync2_q) begin
          state_d = UART_START;
          cnt_d   = HALF_RELOAD;
        end
      end
      UART_START: begin
        if (cnt_q == '0) begin
          if (!sync2_q) begin
            state_d = UART_DATA;
            cnt_d   = FULL_RELOAD;
            bit_d   = '0;
          end else begin
            state_d = UART_IDLE;  // glitch shorter than half a bit
          end
        end
      end
      UART_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {sync2_q, shift_q[7:1]};  // LSB arrives first
          cnt_d   = FULL_RELOAD;
          if (bit_q == 3'd7) state_d = UART_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      UART_STOP: begin
        if (cnt_q == '0) begin
          state_d = UART_IDLE;
          done    = sync2_q;  // stop=0 is a framing error: byte discarded
        end
      end
      default: state_d = UART_IDLE;
    endcase

    if (rd_clr)  rxvalid_d = 1'b0;
    if (err_clr) overrun_d = 1'b0;
    // A completing byte wins over a same-cycle read clear.
    if (done) begin
      rxbuf_d   = shift_q;
      rxvalid_d = 1'b1;
      if (rxvalid_q && !rd_clr) overrun_d = 1'b1;
    end
  end

endmodule

// File: rtl/m_uart_sequencer.sv
// Wishbone IO slave owning the icebreaker serial pins: 8N1 transmitter with a
// one-deep holding register, 8N1 receiver, and a bitbang override of TX.
// Ports:
//   CLK_I, RST_I   clock / synchronous active-high reset
//   wb             Wishbone slot (STB_I, WE_I, ADR_I, DAT_I, DAT_O, ACK_O)
//   usartRX        asynchronous serial input pin
//   usartTX        registered serial output pin
//   dbg_tx_state   TX FSM state (debug)
//   dbg_rx_state   RX FSM state (debug)
module m_uart_sequencer
  import m_uart_sequencer_pkg::*;
#(
  parameter int BAUDDIV = 104,
  parameter int DIVW    = 16
) (
  input  logic                CLK_I,
  input  logic                RST_I,
  m_uart_sequencer_if.slave   wb,
  input  logic                usartRX,
  output logic                usartTX,
  output uart_state_e         dbg_tx_state,
  output uart_state_e         dbg_rx_state
);

  localparam logic [DIVW-1:0] FULL_RELOAD = DIVW'(BAUDDIV - 1);

  // Bus decode
  logic wr_data, wr_ctrl, rd_data, clr_err;
  assign wr_data = wb.STB_I &&  wb.WE_I && (wb.ADR_I == REG_DATA);
  assign wr_ctrl = wb.STB_I &&  wb.WE_I && (wb.ADR_I == REG_CTRL);
  assign rd_data = wb.STB_I && !wb.WE_I && (wb.ADR_I == REG_DATA);
  assign clr_err = wr_ctrl && wb.DAT_I[CTRL_CLRERR];

  logic unused_dat;
  assign unused_dat = ^wb.DAT_I[31:8];

  // Receiver
  logic       rxs, rxvalid, overrun;
  logic [7:0] rxbuf;

  m_uart_rx #(.BAUDDIV(BAUDDIV), .DIVW(DIVW)) u_rx (
    .CLK_I   (CLK_I),
    .RST_I   (RST_I),
    .rx_pin  (usartRX),
    .rd_clr  (rd_data),
    .err_clr (clr_err),
    .rxs     (rxs),
    .rxbuf   (rxbuf),
    .rxvalid (rxvalid),
    .overrun (overrun),
    .state   (dbg_rx_state)
  );

  // Transmitter state
  uart_state_e     tx_state_q, tx_state_d;
  logic [DIVW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic [7:0]      hold_q, hold_d;
  logic            txfull_q, txfull_d;
  logic            txdrop_q, txdrop_d;
  logic            bbmode_q, bbmode_d;
  logic            bbval_q, bbval_d;
  logic            pin_q, pin_d;
  logic            line_d;
  logic            load;

  assign usartTX      = pin_q;
  assign dbg_tx_state = tx_state_q;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      tx_state_q <= UART_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      hold_q     <= '0;
      txfull_q   <= 1'b0;
      txdrop_q   <= 1'b0;
      bbmode_q   <= 1'b0;
      bbval_q    <= 1'b1;
      pin_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      hold_q     <= hold_d;
      txfull_q   <= txfull_d;
      txdrop_q   <= txdrop_d;
      bbmode_q   <= bbmode_d;
      bbval_q    <= bbval_d;
      pin_q      <= pin_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = (tx_cnt_q != '0) ? tx_cnt_q - 1'b1 : tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    hold_d     = hold_q;
    txfull_d   = txfull_q;
    txdrop_d   = txdrop_q;
    bbmode_d   = bbmode_q;
    bbval_d    = bbval_q;
    load       = 1'b0;

    case (tx_state_q)
      UART_IDLE: begin
        if (txfull_q && !bbmode_q) load = 1'b1;
      end
      UART_START: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = UART_DATA;
          tx_cnt_d   = FULL_RELOAD;
          tx_bit_d   = '0;
        end
      end
      UART_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d   = FULL_RELOAD;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) tx_state_d = UART_STOP;
          else                  tx_bit_d   = tx_bit_q + 3'd1;
        end
      end
      UART_STOP: begin
        if (tx_cnt_q == '0) begin
          // Chain straight into the next START so back-to-back bytes leave no gap.
          if (txfull_q && !bbmode_q) load = 1'b1;
          else                       tx_state_d = UART_IDLE;
        end
      end
      default: tx_state_d = UART_IDLE;
    endcase

    if (load) begin
      tx_state_d = UART_START;
      tx_cnt_d   = FULL_RELOAD;
      tx_shift_d = hold_q;
      txfull_d   = 1'b0;
    end

    // Acceptance is judged on the registered flag, so a write landing on the
    // same cycle the holding register is emptied is still dropped.
    if (wr_data) begin
      if (!txfull_q) begin
        hold_d   = wb.DAT_I[7:0];
        txfull_d = 1'b1;
      end else begin
        txdrop_d = 1'b1;
      end
    end

    if (wr_ctrl) begin
      bbmode_d = wb.DAT_I[CTRL_BBMODE];
      bbval_d  = wb.DAT_I[CTRL_BBVAL];
      if (wb.DAT_I[CTRL_CLRERR]) txdrop_d = 1'b0;
    end

    // Pin register is fed from next-state values so a state change or CTRL
    // write shows on the pin right after the edge that causes it.
    case (tx_state_d)
      UART_START: line_d = 1'b0;
      UART_DATA:  line_d = tx_shift_d[0];
      default:    line_d = 1'b1;
    endcase
    pin_d = bbmode_d ? bbval_d : line_d;
  end

  // Zero-wait-state bus response
  assign wb.ACK_O = wb.STB_I;

  always_comb begin
    wb.DAT_O = '0;
    if (wb.STB_I) begin
      if (wb.ADR_I == REG_CTRL)
        wb.DAT_O = pack_status(rxs, txdrop_q, overrun, rxvalid, txfull_q,
                               tx_state_q != UART_IDLE);
      else
        wb.DAT_O = {24'b0, rxbuf};
    end
  end

endmodule

// File: tb/tb_m_uart_sequencer.sv
// Bench for m_uart_sequencer with BAUDDIV=8: register/bitbang vector table,
// then hand-written TX, RX, bitbang and reset sequences. The TX pin is
// recorded every cycle and compared against an expected waveform queue.
module tb_m_uart_sequencer;
  import m_uart_sequencer_pkg::*;

  localparam int BAUD = 8;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        usart_rx = 1'b1;
  logic        usart_tx;
  uart_state_e dbg_tx, dbg_rx;

  m_uart_sequencer_if bus();

  m_uart_sequencer #(.BAUDDIV(BAUD), .DIVW(16)) dut (
    .CLK_I        (clk),
    .RST_I        (rst),
    .wb           (bus.slave),
    .usartRX      (usart_rx),
    .usartTX      (usart_tx),
    .dbg_tx_state (dbg_tx),
    .dbg_rx_state (dbg_rx)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected and recorded TX pin / txbusy waveforms
  logic [0:0] exp_q[$];
  logic [0:0] tx_rec[$];
  logic [0:0] busy_exp[$];
  logic [0:0] busy_rec[$];
  bit rec_en  = 1'b0;
  bit busy_en = 1'b0;

  always @(posedge clk) begin
    #2;
    if (rec_en)  tx_rec.push_back(usart_tx);
    if (busy_en) busy_rec.push_back(bus.DAT_O[ST_TXBUSY]);
  end

  // Bus rules checked every cycle
  always @(posedge clk) begin
    #2;
    checks++;
    if (bus.ACK_O !== bus.STB_I) begin
      errors++;
      $display("FAIL ack_eq_stb ACK_O=%b STB_I=%b t=%0t", bus.ACK_O, bus.STB_I, $time);
    end
    if (!bus.STB_I) begin
      checks++;
      if (bus.DAT_O !== 32'h0) begin
        errors++;
        $display("FAIL dat_o_idle DAT_O=0x%08h required=0x00000000 t=%0t", bus.DAT_O, $time);
      end
    end
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // Driver tasks: called at a negedge, return at a negedge
  task automatic wb_write(input logic adr, input logic [31:0] d);
    bus.STB_I = 1'b1;
    bus.WE_I  = 1'b1;
    bus.ADR_I = adr;
    bus.DAT_I = d;
    @(negedge clk);
    bus.STB_I = 1'b0;
    bus.WE_I  = 1'b0;
    bus.DAT_I = 32'h0;
  endtask

  task automatic wb_read(input logic adr, output logic [31:0] d);
    bus.STB_I = 1'b1;
    bus.WE_I  = 1'b0;
    bus.ADR_I = adr;
    #1 d = bus.DAT_O;
    @(negedge clk);
    bus.STB_I = 1'b0;
  endtask

  task automatic read_check(input string name, input logic adr, input logic [31:0] exp);
    logic [31:0] d;
    wb_read(adr, d);
    check32(name, d, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    usart_rx = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      usart_rx = b[i];
      repeat (BAUD) @(negedge clk);
    end
    usart_rx = stop;
    repeat (BAUD) @(negedge clk);
    usart_rx = 1'b1;
  endtask

  task automatic push_frame(input logic [7:0] b);
    for (int i = 0; i < BAUD; i++) exp_q.push_back(1'b0);
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < BAUD; i++) exp_q.push_back(b[k]);
    for (int i = 0; i < BAUD; i++) exp_q.push_back(1'b1);
  endtask

  task automatic compare_tx(input string name);
    int budget;
    budget = 0;
    while (tx_rec.size() < exp_q.size() && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    rec_en = 1'b0;
    checks++;
    if (tx_rec.size() < exp_q.size()) begin
      errors++;
      $display("FAIL %s_timeout recorded=%0d required=%0d", name, tx_rec.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (tx_rec[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s[%0d] usartTX=%b required=%b", name, i, tx_rec[i], exp_q[i]);
        end
      end
    end
    tx_rec.delete();
    exp_q.delete();
  endtask

  // Register / bitbang vector table
  typedef struct {
    logic        we;
    logic        adr;
    logic [31:0] wdat;
    logic [31:0] exp_rd;
    logic        exp_tx;
  } vec_t;

  vec_t vecs[15];

  initial begin
    logic [31:0] rd;

    vecs[0]  = '{1'b0, REG_CTRL, 32'h0,  32'h100, 1'b1};  // reset STATUS
    vecs[1]  = '{1'b0, REG_DATA, 32'h0,  32'h000, 1'b1};  // reset rxbuf
    vecs[2]  = '{1'b1, REG_CTRL, 32'h1,  32'h0,   1'b0};  // bbmode, bbval=0
    vecs[3]  = '{1'b0, REG_CTRL, 32'h0,  32'h100, 1'b0};
    vecs[4]  = '{1'b1, REG_CTRL, 32'h3,  32'h0,   1'b1};  // bbval=1
    vecs[5]  = '{1'b1, REG_CTRL, 32'h1,  32'h0,   1'b0};
    vecs[6]  = '{1'b1, REG_CTRL, 32'h0,  32'h0,   1'b1};  // back to idle FSM
    vecs[7]  = '{1'b1, REG_CTRL, 32'h2,  32'h0,   1'b1};  // bbval alone has no effect
    vecs[8]  = '{1'b1, REG_CTRL, 32'h1,  32'h0,   1'b0};
    vecs[9]  = '{1'b1, REG_DATA, 32'h5A, 32'h0,   1'b0};  // held while in bbmode
    vecs[10] = '{1'b0, REG_CTRL, 32'h0,  32'h102, 1'b0};  // txfull, not busy
    vecs[11] = '{1'b1, REG_DATA, 32'h11, 32'h0,   1'b0};  // dropped
    vecs[12] = '{1'b0, REG_CTRL, 32'h0,  32'h112, 1'b0};  // txdrop
    vecs[13] = '{1'b1, REG_CTRL, 32'h13, 32'h0,   1'b1};  // clear + bbval=1
    vecs[14] = '{1'b0, REG_CTRL, 32'h0,  32'h102, 1'b1};

    bus.STB_I = 1'b0;
    bus.WE_I  = 1'b0;
    bus.ADR_I = 1'b0;
    bus.DAT_I = 32'h0;

    // Reset
    idle(3);
    check1("reset_tx", usart_tx, 1'b1);
    check1("reset_tx_idle", dbg_tx == UART_IDLE, 1'b1);
    check1("reset_rx_idle", dbg_rx == UART_IDLE, 1'b1);
    rst = 1'b0;
    idle(2);

    // Table
    for (int v = 0; v < 15; v++) begin
      if (vecs[v].we) begin
        wb_write(vecs[v].adr, vecs[v].wdat);
      end else begin
        wb_read(vecs[v].adr, rd);
        check32($sformatf("vec%0d_rd", v), rd, vecs[v].exp_rd);
      end
      check1($sformatf("vec%0d_tx", v), usart_tx, vecs[v].exp_tx);
    end

    // Byte queued during bbmode goes out once bbmode clears
    exp_q.push_back(1'b1);
    push_frame(8'h5A);
    repeat (8) exp_q.push_back(1'b1);
    rec_en = 1'b1;
    wb_write(REG_CTRL, 32'h0);
    compare_tx("queued_5a");
    read_check("queued_status", REG_CTRL, 32'h100);

    // Single frame 0x55 with txbusy watched every cycle
    exp_q.push_back(1'b1);
    push_frame(8'h55);
    repeat (8) exp_q.push_back(1'b1);
    for (int i = 0; i < 80; i++) busy_exp.push_back(1'b1);
    for (int i = 0; i < 8; i++)  busy_exp.push_back(1'b0);
    rec_en = 1'b1;
    wb_write(REG_DATA, 32'h55);
    bus.STB_I = 1'b1;
    bus.WE_I  = 1'b0;
    bus.ADR_I = REG_CTRL;
    busy_en   = 1'b1;
    compare_tx("frame_55");
    busy_en   = 1'b0;
    bus.STB_I = 1'b0;
    checks++;
    if (busy_rec.size() < busy_exp.size()) begin
      errors++;
      $display("FAIL busy_len recorded=%0d required=%0d", busy_rec.size(), busy_exp.size());
    end else begin
      for (int i = 0; i < busy_exp.size(); i++) begin
        checks++;
        if (busy_rec[i] !== busy_exp[i]) begin
          errors++;
          $display("FAIL txbusy[%0d] actual=%b required=%b", i, busy_rec[i], busy_exp[i]);
        end
      end
    end
    busy_rec.delete();
    busy_exp.delete();

    // Back-to-back 0xA5, 0x3C; third write dropped
    exp_q.push_back(1'b1);
    push_frame(8'hA5);
    push_frame(8'h3C);
    repeat (8) exp_q.push_back(1'b1);
    rec_en = 1'b1;
    wb_write(REG_DATA, 32'hA5);
    idle(1);
    wb_write(REG_DATA, 32'h3C);
    wb_write(REG_DATA, 32'hFF);
    read_check("b2b_status_drop", REG_CTRL, 32'h113);
    wb_write(REG_CTRL, 32'h10);
    read_check("b2b_status_clr", REG_CTRL, 32'h103);
    compare_tx("b2b_a5_3c");
    read_check("b2b_status_end", REG_CTRL, 32'h100);

    // RX single frame
    send_rx(8'hC3, 1'b1);
    read_check("rx_c3_status", REG_CTRL, 32'h104);
    read_check("rx_c3_data", REG_DATA, 32'hC3);
    read_check("rx_c3_cleared", REG_CTRL, 32'h100);

    // RX overrun
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    read_check("ovr_status", REG_CTRL, 32'h10C);
    read_check("ovr_data", REG_DATA, 32'h22);
    read_check("ovr_status_rd", REG_CTRL, 32'h108);
    wb_write(REG_CTRL, 32'h10);
    read_check("ovr_status_clr", REG_CTRL, 32'h100);

    // RX glitch
    usart_rx = 1'b0;
    idle(3);
    usart_rx = 1'b1;
    idle(40);
    read_check("glitch_status", REG_CTRL, 32'h100);

    // Framing error leaves the earlier byte in place
    send_rx(8'h77, 1'b1);
    read_check("frm_good_status", REG_CTRL, 32'h104);
    send_rx(8'h5A, 1'b0);
    idle(4);
    read_check("frm_bad_status", REG_CTRL, 32'h104);
    read_check("frm_data", REG_DATA, 32'h77);
    read_check("frm_cleared", REG_CTRL, 32'h100);

    // Bitbang override mid-frame (0x0F)
    exp_q.push_back(1'b1);
    push_frame(8'h0F);
    repeat (8) exp_q.push_back(1'b1);
    for (int i = 20; i < 30; i++) exp_q[i] = 1'b0;
    for (int i = 30; i < 40; i++) exp_q[i] = 1'b1;
    rec_en = 1'b1;
    wb_write(REG_DATA, 32'h0F);
    idle(19);
    wb_write(REG_CTRL, 32'h1);
    idle(9);
    wb_write(REG_CTRL, 32'h3);
    idle(9);
    wb_write(REG_CTRL, 32'h0);
    compare_tx("bb_midframe");

    // STATUS[8] lags usartRX by two cycles, also in bbmode
    wb_write(REG_CTRL, 32'h3);
    bus.STB_I = 1'b1;
    bus.WE_I  = 1'b0;
    bus.ADR_I = REG_CTRL;
    usart_rx  = 1'b0;
    #1 check1("rxs_lag0", bus.DAT_O[ST_RXS], 1'b1);
    @(negedge clk);
    #1 check1("rxs_lag1", bus.DAT_O[ST_RXS], 1'b1);
    @(negedge clk);
    #1 check1("rxs_lag2", bus.DAT_O[ST_RXS], 1'b0);
    usart_rx = 1'b1;
    @(negedge clk);
    #1 check1("rxs_lag3", bus.DAT_O[ST_RXS], 1'b0);
    @(negedge clk);
    #1 check1("rxs_lag4", bus.DAT_O[ST_RXS], 1'b1);
    bus.STB_I = 1'b0;
    @(negedge clk);
    wb_write(REG_CTRL, 32'h0);
    idle(20);
    read_check("rxs_status", REG_CTRL, 32'h100);

    // Reset during data bit 3 of both TX and RX
    fork
      send_rx(8'hF7, 1'b1);
      begin
        wb_write(REG_DATA, 32'h00);
        idle(35);
        check1("pre_rst_tx", usart_tx, 1'b0);
        check1("pre_rst_busy", dbg_tx == UART_DATA, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check1("rst_mid_tx", usart_tx, 1'b1);
        check1("rst_mid_tx_idle", dbg_tx == UART_IDLE, 1'b1);
        check1("rst_mid_rx_idle", dbg_rx == UART_IDLE, 1'b1);
        wb_read(REG_CTRL, rd);
        check32("rst_mid_status", rd & 32'h1F, 32'h0);
      end
    join
    idle(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
